// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: register-access command sequencer behind a UART receiver.
//
// It collects received bytes into packets and checks each packet before acting on it:
//   write: HDR 01 ADDR DHI DLO CSUM
//   read : HDR 02 ADDR CSUM
// CSUM is the XOR of every byte after HDR. A packet that passes the check
// produces a one-cycle wr_en or rd_en strobe.
// A read then waits for rd_valid. It sends the 16-bit result high byte
// first, using a tx_start/tx_done handshake for each byte.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   s_tck               baud oversampling tick, drives the inter-byte timeout
//   rx_done_tck/rx_data received byte strobe and data
//   wr_en/rd_en         one-cycle register strobes
//   reg_addr/wr_data    register address and write data (held)
//   rd_valid/rd_data    read data return
//   tx_start/tx_data    transmit request and byte (byte held until next start)
//   tx_done             transmitter finished the current byte
//   busy                high whenever a packet is in progress
//   err/err_code        one-cycle error pulse; code 01 csum, 10 cmd, 11 timeout
module uart_cmd_ctrl #(
  parameter int         TIMEOUT_TCK = 4096,
  parameter logic [7:0] HDR         = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_tck,
  input  logic        rx_done_tck,
  input  logic [7:0]  rx_data,
  output logic        wr_en,
  output logic        rd_en,
  output logic [7:0]  reg_addr,
  output logic [15:0] wr_data,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [7:0]  CMD_WR   = 8'h01;
  localparam logic [7:0]  CMD_RD   = 8'h02;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_TCK - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DHI, S_DLO, S_CSUM,
    S_EXEC, S_RD_WAIT, S_TX_HI, S_TX_LO
  } state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  acc_q, acc_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  rd_lo_q, rd_lo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic in_frame;
  logic tmo_hit;

  // The timeout applies only while a packet is being received.
  // If a byte arrives in the same cycle as the timeout, the byte is processed.
  assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DHI) ||
                    (state_q == S_DLO) || (state_q == S_CSUM);
  assign tmo_hit  = in_frame && s_tck && !rx_done_tck && (tmo_q == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rx_done_tck && rx_data == HDR) state_d = S_CMD;
      S_CMD:     if (rx_done_tck)
                   state_d = (rx_data == CMD_WR || rx_data == CMD_RD) ? S_ADDR : S_IDLE;
                 else if (tmo_hit) state_d = S_IDLE;
      S_ADDR:    if (rx_done_tck) state_d = is_wr_q ? S_DHI : S_CSUM;
                 else if (tmo_hit) state_d = S_IDLE;
      S_DHI:     if (rx_done_tck) state_d = S_DLO;
                 else if (tmo_hit) state_d = S_IDLE;
      S_DLO:     if (rx_done_tck) state_d = S_CSUM;
                 else if (tmo_hit) state_d = S_IDLE;
      S_CSUM:    if (rx_done_tck) state_d = (rx_data == acc_q) ? S_EXEC : S_IDLE;
                 else if (tmo_hit) state_d = S_IDLE;
      S_EXEC:    state_d = is_wr_q ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: if (rd_valid) state_d = S_TX_HI;
      S_TX_HI:   if (tx_done) state_d = S_TX_LO;
      S_TX_LO:   if (tx_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: field latches, checksum, timeout, tx and error pulses
  always_comb begin
    is_wr_d    = is_wr_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_lo_d    = rd_lo_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (!in_frame || rx_done_tck) tmo_d = '0;
    else if (s_tck)               tmo_d = tmo_q + 16'd1;
    else                          tmo_d = tmo_q;

    if (tmo_hit) begin
      err_d      = 1'b1;
      err_code_d = 2'b11;
    end

    case (state_q)
      S_IDLE: if (rx_done_tck && rx_data == HDR) acc_d = '0;
      S_CMD: if (rx_done_tck) begin
        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
          is_wr_d = (rx_data == CMD_WR);
          acc_d   = acc_q ^ rx_data;
        end else begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end
      end
      S_ADDR: if (rx_done_tck) begin
        addr_d = rx_data;
        acc_d  = acc_q ^ rx_data;
      end
      S_DHI: if (rx_done_tck) begin
        wdata_d[15:8] = rx_data;
        acc_d         = acc_q ^ rx_data;
      end
      S_DLO: if (rx_done_tck) begin
        wdata_d[7:0] = rx_data;
        acc_d        = acc_q ^ rx_data;
      end
      S_CSUM: if (rx_done_tck && rx_data != acc_q) begin
        err_d      = 1'b1;
        err_code_d = 2'b01;
      end
      // The high byte goes straight out. Only the low byte is kept for later.
      S_RD_WAIT: if (rd_valid) begin
        rd_lo_d    = rd_data[7:0];
        tx_data_d  = rd_data[15:8];
        tx_start_d = 1'b1;
      end
      S_TX_HI: if (tx_done) begin
        tx_data_d  = rd_lo_q;
        tx_start_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_wr_q    <= 1'b0;
      acc_q      <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_lo_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      is_wr_q    <= is_wr_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_lo_q    <= rd_lo_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Output logic. Strobes come from EXEC. tx_start and err are registered
  // pulses that only fire on entry to TX/IDLE, so they never overlap the strobes.
  always_comb begin
    wr_en    = (state_q == S_EXEC) && is_wr_q;
    rd_en    = (state_q == S_EXEC) && !is_wr_q;
    busy     = (state_q != S_IDLE);
    reg_addr = addr_q;
    wr_data  = wdata_q;
    tx_start = tx_start_q;
    tx_data  = tx_data_q;
    err      = err_q;
    err_code = err_code_q;
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl. The stimulus pushes the expected
// output events (wr, rd, tx, err) into an ordered queue. The monitor branch
// watches the DUT on every falling edge and pops one entry per event.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_tck = 1'b0;
  logic        rx_done_tck = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_en, rd_en, tx_start, busy, err;
  logic [7:0]  reg_addr, tx_data;
  logic [15:0] wr_data;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        tx_done = 1'b0;
  logic [1:0]  err_code;

  uart_cmd_ctrl dut (
    .clk(clk), .reset(reset), .s_tck(s_tck),
    .rx_done_tck(rx_done_tck), .rx_data(rx_data),
    .wr_en(wr_en), .rd_en(rd_en), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  localparam int K_WR = 0, K_RD = 1, K_TX = 2, K_ERR = 3;
  typedef struct { int kind; logic [23:0] val; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int last_rx = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic handle(input int kind, input logic [23:0] val);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: actual kind=%0d val=%h required=none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        errors++;
        $display("FAIL event_match: actual kind=%0d val=%h required kind=%0d val=%h",
                 kind, val, e.kind, e.val);
      end else begin
        $display("event kind=%0d val=%h ok at cycle %0d", kind, val, ncyc);
      end
    end
  endtask

  task automatic push(input int kind, input logic [23:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic tck);
    @(posedge clk); #1;
    rx_done_tck = 1'b1; rx_data = b; s_tck = tck;
    @(posedge clk); #1;
    rx_done_tck = 1'b0; s_tck = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b []);
    foreach (b[i]) send_byte(b[i], 1'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1; s_tck = 1'b1;
    end
    @(posedge clk); #1; s_tck = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1; tx_done = 1'b1;
    @(posedge clk); #1; tx_done = 1'b0;
  endtask

  task automatic wait_tx(input string name);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      // Monitor
      forever begin
        @(negedge clk);
        ncyc++;
        if (int'(wr_en) + int'(rd_en) + int'(tx_start) + int'(err) > 1)
          check("exclusive_pulses", {28'd0, wr_en, rd_en, tx_start, err}, 32'd0);
        if (wr_en) begin
          handle(K_WR, {reg_addr, wr_data});
          check("wr_latency", ncyc - last_rx, 1);
        end
        if (rd_en) begin
          handle(K_RD, {16'd0, reg_addr});
          check("rd_latency", ncyc - last_rx, 1);
        end
        if (tx_start) handle(K_TX, {16'd0, tx_data});
        if (err)      handle(K_ERR, {22'd0, err_code});
        if (rx_done_tck) last_rx = ncyc;
      end
      // Stimulus
      begin
        wait_cycles(3);
        @(negedge clk);
        check("reset_outputs", {wr_en, rd_en, tx_start, err, busy, err_code, reg_addr, wr_data, tx_data},
              32'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Valid write
        push(K_WR, {8'h10, 16'h1234});
        send_pkt('{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37});
        wait_cycles(2);
        check("busy_after_write", {31'd0, busy}, 32'd0);

        // Valid read, rd_valid 3 cycles after the strobe
        push(K_RD, 24'h20);
        push(K_TX, 24'hBE);
        push(K_TX, 24'hEF);
        send_pkt('{8'hA5, 8'h02, 8'h20, 8'h22});
        wait_cycles(4);
        rd_data = 16'hBEEF; rd_valid = 1'b1;
        @(posedge clk); #1; rd_valid = 1'b0; rd_data = 16'h0000;
        wait_tx("tx_hi_seen");
        wait_cycles(3);
        pulse_tx_done();
        wait_tx("tx_lo_seen");
        @(negedge clk);
        check("busy_in_tx_lo", {31'd0, busy}, 32'd1);
        pulse_tx_done();
        @(negedge clk);
        check("busy_after_read", {31'd0, busy}, 32'd0);

        // Bad checksum, then a valid write
        push(K_ERR, 24'h1);
        send_pkt('{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h36});
        wait_cycles(2);
        push(K_WR, {8'h55, 16'hAA00});
        send_pkt('{8'hA5, 8'h01, 8'h55, 8'hAA, 8'h00, 8'hFE});
        wait_cycles(2);

        // Bad command. The bytes after it are ignored until the next header.
        push(K_ERR, 24'h2);
        send_pkt('{8'hA5, 8'h07, 8'h01, 8'h10});
        @(negedge clk);
        check("busy_after_badcmd", {31'd0, busy}, 32'd0);
        check("err_code_held", {30'd0, err_code}, 32'd2);

        // Timeout at the 4096th tick
        push(K_ERR, 24'h3);
        send_pkt('{8'hA5, 8'h01, 8'h10});
        tick(4095);
        @(negedge clk);
        check("busy_before_timeout", {31'd0, busy}, 32'd1);
        tick(1);
        @(negedge clk);
        check("busy_after_timeout", {31'd0, busy}, 32'd0);

        // A byte that arrives in the timeout cycle takes priority over the timeout
        push(K_WR, {8'h10, 16'h5678});
        send_pkt('{8'hA5, 8'h01, 8'h10});
        tick(4095);
        send_byte(8'h56, 1'b1);
        send_pkt('{8'h78, 8'h3F});
        wait_cycles(2);

        // Reset during TX_HI
        push(K_RD, 24'h30);
        push(K_TX, 24'hCA);
        send_pkt('{8'hA5, 8'h02, 8'h30, 8'h32});
        wait_cycles(2);
        rd_data = 16'hCAFE; rd_valid = 1'b1;
        @(posedge clk); #1; rd_valid = 1'b0;
        wait_tx("tx_hi_before_reset");
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("outputs_after_reset",
              {wr_en, rd_en, tx_start, err, busy, err_code, reg_addr, wr_data, tx_data}, 32'd0);
        pulse_tx_done();
        wait_cycles(10);
        check("queue_empty", exp_q.size(), 0);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer behind the UART receiver; consumes its byte stream (done tick plus data byte).
- Frames bytes into register-access packets, validates them, then issues one-cycle register write/read strobes.
- For reads, sequences the 2-byte response through the UART transmitter via a start/done handshake.
- Gives the host a register port into the design over the serial link.

Parameters:
- TIMEOUT_TCK, 4096: number of s_tck oversampling ticks allowed between bytes of a packet before it is aborted.
- HDR, 8'hA5: packet header byte.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_tck  in  1  baud oversampling tick (16 per bit), used for timeout
- rx_done_tck  in  1  one-cycle pulse, rx_data valid this cycle
- rx_data  in  8  received byte
- wr_en  out  1  one-cycle register write strobe
- rd_en  out  1  one-cycle register read strobe
- reg_addr  out  8  register address, held from ADDR byte until next packet
- wr_data  out  16  write data, held after DLO
- rd_valid  in  1  read data valid pulse
- rd_data  in  16  read data, sampled when rd_valid=1
- tx_start  out  1  one-cycle pulse, tx_data valid
- tx_data  out  8  byte to transmit, held until tx_done
- tx_done  in  1  transmitter finished byte
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle error pulse
- err_code  out  2  01 checksum, 10 bad command, 11 timeout; held until next err

Behaviour:
- Packet format:
  - Write: HDR, CMD=8'h01, ADDR, DHI, DLO, CSUM.
  - Read: HDR, CMD=8'h02, ADDR, CSUM.
  - CSUM = XOR of all bytes after HDR and before CSUM.
- Reset: state IDLE; all outputs 0; checksum accumulator 0; timeout counter 0.
- States: IDLE, CMD, ADDR, DHI, DLO, CSUM, EXEC, RD_WAIT, TX_HI, TX_LO. All transitions are on rx_done_tck unless stated.
- IDLE:
  - Byte==HDR -> CMD; clear accumulator.
  - Any other byte is ignored silently.
- CMD:
  - 01 or 02 -> latch command, acc^=byte, go ADDR.
  - Any other value -> err, code 10, go IDLE.
- ADDR: latch reg_addr, acc^=byte. Write -> DHI; read -> CSUM.
- DHI / DLO: latch wr_data[15:8] / [7:0], acc^=byte, go DLO / CSUM.
- CSUM:
  - byte!=acc -> err, code 01, go IDLE; no strobe issued.
  - Otherwise go EXEC.
- EXEC (single cycle):
  - Write: wr_en=1, go IDLE.
  - Read: rd_en=1, go RD_WAIT.
  - Latency: strobe is asserted exactly 1 cycle after the CSUM rx_done_tck.
- RD_WAIT: on rd_valid, latch rd_data. Next cycle tx_start=1 with tx_data=rd_data[15:8], go TX_HI. No timeout in this state.
- TX_HI: on tx_done, next cycle tx_start=1 with tx_data=rd_data[7:0], go TX_LO.
- TX_LO: on tx_done -> IDLE.
- Timeout:
  - 16-bit counter, cleared on every rx_done_tck and in IDLE; increments on s_tck in CMD..CSUM.
  - Reaching TIMEOUT_TCK-1 with s_tck -> err, code 11, go IDLE.
  - If rx_done_tck and the timeout occur in the same cycle, the byte wins: it is processed and the counter is cleared.
- Bytes arriving in EXEC, RD_WAIT, TX_HI or TX_LO are dropped with no error; the header is not searched for until IDLE.
- tx_done or rd_valid arriving outside its wait state is ignored.
- reset mid-packet or mid-transmit: synchronous return to IDLE on the next edge. Partial packet is discarded; pending tx_start is not issued.
- wr_en, rd_en, tx_start and err never assert in the same cycle as each other.

Test Plan:
- Write A5 01 10 12 34 37 -> wr_en single pulse 1 cycle after last rx_done_tck; reg_addr=8'h10, wr_data=16'h1234; err=0.
- Read A5 02 20 22; rd_valid with 16'hBEEF 3 cycles later -> rd_en pulse, addr=8'h20; tx_start with 8'hBE; after tx_done, tx_start with 8'hEF; busy falls after second tx_done.
- Write A5 01 10 12 34 36 (bad checksum) -> err pulse, err_code=01, no wr_en; a following valid packet executes normally.
- A5 07 -> err, err_code=10 immediately; subsequent bytes 01 10 ignored until a new A5 arrives.
- A5 01 10 followed by 4096 s_tck with no byte -> err, err_code=11, back in IDLE. Same test with a byte on the timeout cycle -> no error, packet continues.
- Reset asserted during TX_HI -> all outputs 0 next cycle; later tx_done produces no tx_start.
